sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 512, number of storage entries (any value >= 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port din_a, input, FIFO_WIDTH, write data.
REQ-006 SHALL have port wen_a, input, 1, write enable.
REQ-007 SHALL have port ren_b, input, 1, read enable.
REQ-008 SHALL have port dout_b, output, FIFO_WIDTH, registered read data.
REQ-009 SHALL have port full, output, 1, high when count == FIFO_DEPTH.
REQ-010 SHALL have port empty, output, 1, high when count == 0.
REQ-011 SHALL have port count, output, clog2(FIFO_DEPTH)+1, number of stored words.
REQ-012 SHALL have port overflow, output, 1, registered pulse for a rejected write.
REQ-013 SHALL have port underflow, output, 1, registered pulse for a rejected read.

Function
REQ-014 SHALL store FIFO_DEPTH words of FIFO_WIDTH bits in an internal memory, with a write pointer and a read pointer.
REQ-015 SHALL accept a write when wen_a=1 and full=0 at the clock edge: mem[wr_ptr] <= din_a, and wr_ptr advances by 1.
REQ-016 SHALL accept a read when ren_b=1 and empty=0 at the clock edge: dout_b <= mem[rd_ptr], and rd_ptr advances by 1; the data is visible the cycle after the read edge (1-cycle latency).
REQ-017 SHALL hold dout_b unchanged on every cycle without an accepted read.
REQ-018 SHALL wrap each pointer from FIFO_DEPTH-1 to 0 (circular buffer); wrap SHALL NOT corrupt data ordering.
REQ-019 SHALL update count by +1 on write-only, -1 on read-only, and leave it unchanged when both a write and a read are accepted or when neither is.
REQ-020 SHALL derive full and empty combinationally from the registered count; both are valid in the same cycle count changes.
REQ-021 SHALL reject a write attempted while full=1, even if a read is accepted in the same cycle; memory, wr_ptr and count are unaffected by the rejected write; overflow=1 for the following cycle only.
REQ-022 SHALL reject a read attempted while empty=1, even if a write is accepted in the same cycle; dout_b, rd_ptr and count are unaffected by the rejected read; underflow=1 for the following cycle only.
REQ-023 SHALL, when both requests are accepted in the same cycle, perform both; count stays constant, and the read returns the oldest word (never the word written that cycle).
REQ-024 SHALL preserve strict first-in first-out order for all accepted words.
REQ-025 SHALL treat X on wen_a or ren_b as a don't-care only while rst=1.

Reset
REQ-026 SHALL, on a rising clk edge with rst=1, set wr_ptr=0, rd_ptr=0, count=0, dout_b=0, overflow=0 and underflow=0; empty=1 and full=0 result.
REQ-027 SHALL give rst priority over wen_a and ren_b in the same cycle; memory contents need not be cleared.
REQ-028 SHALL discard all stored data when reset is asserted mid-operation; the first read after reset returns the first word written after reset.

Verification
REQ-029 Scenario: reset, then 512 consecutive writes of words W0..W511 -> full=1 and count=512 after the 512th edge; empty=0 after the 1st write.
REQ-030 Scenario: from full, 1 read, then 1 write of Wn -> dout_b=W0; full drops to 0 then returns to 1; wr_ptr wraps to 1; later reads return W1..W511, then Wn.
REQ-031 Scenario: 10 writes while full -> overflow pulses each cycle; count stays 512; stored data unchanged.
REQ-032 Scenario: 512 reads, then 10 more reads while empty -> all words return in order; underflow pulses on the extra reads; dout_b holds the last valid word.
REQ-033 Scenario: write 100 words, then 100 cycles with wen_a=ren_b=1 -> count stays 100; outputs appear in write order.
REQ-034 Scenario: rst=1 asserted with count=50 -> next cycle count=0, empty=1, dout_b=0.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock first-in first-out buffer built on a circular memory with
//   separate write and read pointers. Read data is registered, so a word
//   appears on dout_b one cycle after the edge that accepted the read.
//   Requests that cannot be honoured are dropped and flagged with a
//   one-cycle overflow or underflow pulse.
//
// Parameters
//   FIFO_WIDTH : data word width in bits
//   FIFO_DEPTH : number of storage entries (>= 2)
//
// Ports
//   clk       : single clock, rising-edge active
//   rst       : synchronous active-high reset
//   din_a     : write data
//   wen_a     : write enable
//   ren_b     : read enable
//   dout_b    : registered read data, held between accepted reads
//   full      : count == FIFO_DEPTH
//   empty     : count == 0
//   count     : number of stored words
//   overflow  : pulse the cycle after a rejected write
//   underflow : pulse the cycle after a rejected read
module sync_fifo #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FIFO_WIDTH-1:0]         din_a,
  input  logic                          wen_a,
  input  logic                          ren_b,
  output logic [FIFO_WIDTH-1:0]         dout_b,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic wr_accept;
  logic rd_accept;

  // Flags come straight from the registered count so they track it in the
  // same cycle. Acceptance looks only at the current flags: a read in the
  // same cycle does not make room for a write into a full FIFO, and a write
  // in the same cycle does not supply data for a read from an empty one.
  always_comb begin
    full      = (count == FULL_COUNT);
    empty     = (count == '0);
    wr_accept = wen_a && !full;
    rd_accept = ren_b && !empty;
  end

  // Storage array. It is deliberately not reset so it can map onto a RAM;
  // stale contents are unreachable because the pointers and count are reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr] <= din_a;
    end
  end

  // Write pointer walks the circular buffer, wrapping after the last entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_accept) begin
      wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
    end
  end

  // Read pointer and registered output. mem[rd_ptr] is sampled before this
  // edge's write lands, so a simultaneous read always returns the oldest
  // word; when the FIFO is non-empty rd_ptr never addresses the slot being
  // written anyway unless the FIFO is full, where the write is refused.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      dout_b <= '0;
    end else if (rd_accept) begin
      rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      dout_b <= mem[rd_ptr];
    end
  end

  // Occupancy: a simultaneous accepted read and write cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Error pulses last exactly one cycle after each refused request.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wen_a && full;
      underflow <= ren_b && empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo
//   Randomized, scoreboard-checked bench for sync_fifo. The stimulus side
//   runs a queue-based reference model and pushes the expected output state
//   for every clock edge; an independent monitor pops and compares one
//   record shortly after each rising edge.
module tb_sync_fifo;

  localparam int W     = 16;
  localparam int DEPTH = 512;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [W-1:0]     din_a = '0;
  logic             wen_a = 1'b0;
  logic             ren_b = 1'b0;
  logic [W-1:0]     dout_b;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  typedef struct {
    logic [W-1:0] dout;
    int           cnt;
    bit           ovf;
    bit           unf;
    bit           is_full;
    bit           is_empty;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] model_q[$];
  logic [W-1:0] model_dout = '0;

  int total = 0;
  int bad   = 0;

  sync_fifo #(
    .FIFO_WIDTH(W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_a     (din_a),
    .wen_a     (wen_a),
    .ren_b     (ren_b),
    .dout_b    (dout_b),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Single comparison; every call counts toward the totals.
  task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField("dout_b",    32'(dout_b),    32'(e.dout));
    compareField("count",     32'(count),     32'(e.cnt));
    compareField("full",      32'(full),      32'(e.is_full));
    compareField("empty",     32'(empty),     32'(e.is_empty));
    compareField("overflow",  32'(overflow),  32'(e.ovf));
    compareField("underflow", 32'(underflow), 32'(e.unf));
  endtask

  // Drives one cycle of inputs and advances the reference model for the
  // edge that follows: the FIFO is just a queue bounded at DEPTH entries.
  task automatic applyStimulus(input bit r, input bit w, input bit rd, input logic [W-1:0] d);
    exp_t e;
    bit   wr_ok;
    bit   rd_ok;
    @(negedge clk);
    rst   = r;
    wen_a = w;
    ren_b = rd;
    din_a = d;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (r) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      wr_ok = w  && (model_q.size() < DEPTH);
      rd_ok = rd && (model_q.size() > 0);
      e.ovf = w  && !wr_ok;
      e.unf = rd && !rd_ok;
      if (rd_ok) model_dout = model_q.pop_front();
      if (wr_ok) model_q.push_back(d);
    end
    e.dout     = model_dout;
    e.cnt      = model_q.size();
    e.is_full  = (model_q.size() == DEPTH);
    e.is_empty = (model_q.size() == 0);
    exp_q.push_back(e);
  endtask

  // Monitor: each record pushed before an edge is checked just after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    // Reset, then fill completely.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, W'($urandom));
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, W'($urandom));

    // From full: one read, then one write that wraps the write pointer.
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, W'($urandom));

    // Writes while full, including one paired with a read.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, W'($urandom));
    applyStimulus(1'b0, 1'b1, 1'b1, W'($urandom));
    applyStimulus(1'b0, 1'b1, 1'b0, W'($urandom));

    // Drain completely, then read past empty (with one write paired in).
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, W'($urandom));
    applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // Steady state: 100 words then 100 simultaneous read/write cycles.
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b1, 1'b0, W'($urandom));
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b1, 1'b1, W'($urandom));
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // Reset mid-operation with 50 words stored, then confirm fresh data.
    for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b1, 1'b0, W'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b1, W'($urandom));
    applyStimulus(1'b0, 1'b1, 1'b0, W'($urandom));
    applyStimulus(1'b0, 1'b1, 1'b0, W'($urandom));
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // Random traffic with shifting read/write bias and rare resets.
    for (int phase = 0; phase < 4; phase++) begin
      for (int i = 0; i < 800; i++) begin
        bit w;
        bit rd;
        bit r;
        case (phase)
          0:       begin w = ($urandom_range(99) < 70); rd = ($urandom_range(99) < 30); end
          1:       begin w = ($urandom_range(99) < 30); rd = ($urandom_range(99) < 70); end
          2:       begin w = ($urandom_range(99) < 95); rd = ($urandom_range(99) < 50); end
          default: begin w = ($urandom_range(99) < 50); rd = ($urandom_range(99) < 50); end
        endcase
        r = ($urandom_range(999) < 3);
        applyStimulus(r, w, rd, W'($urandom));
      end
    end

    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    @(posedge clk);
    #2;
    compareField("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
